// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial port transmitter: bus register
// addresses, status bit layout and transmit FSM state encoding.
package serial_port_pkg;

    // Register select values on the one-bit port-bus address
    localparam logic SERIAL_ADDR_DATA    = 1'b0;
    localparam logic SERIAL_ADDR_CONTROL = 1'b1;

    // Bit positions inside the status byte read from SERIAL_ADDR_DATA
    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_BUSY_BIT     = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;

    // Index of the last data bit in an 8N1 frame
    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    // Transmit FSM states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/serial_port_tx_fifo.sv
// Byte FIFO that buffers CPU writes ahead of the transmit shifter.
// Full/empty decisions use the pre-edge count, so a push into a full
// FIFO is dropped even when a pop happens in the same cycle.
module serial_port_tx_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_next
);

    localparam int                  DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == DEPTH_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this edge; a simultaneous push and pop cancel out
    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
        end
    end

    // Byte storage, written only on an accepted push
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; an empty count makes stale contents unreachable.
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/serial_port_transmitter.sv
// 8N1 UART transmitter on the PicoBlaze port bus. CPU writes are queued
// in a FIFO, shifted out LSB-first on txd, and a level interrupt is
// raised once the transmitter has fully drained.
module serial_port_transmitter
    import serial_port_pkg::*;
#(
    parameter int CLOCK_DIVIDER   = 434,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       txd,
    output logic       ready
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLOCK_DIVIDER - 1);

    // Bus decode
    logic write_data;
    logic write_control;
    logic read_status;

    assign write_data    = en &  wr & (addr == SERIAL_ADDR_DATA);
    assign write_control = en &  wr & (addr == SERIAL_ADDR_CONTROL);
    assign read_status   = en & ~wr & (addr == SERIAL_ADDR_DATA);

    // FIFO interface
    logic                     fifo_pop;
    logic [7:0]               fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic [FIFO_DEPTH_LOG2:0] fifo_count_next;

    serial_port_tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (write_data),
        .push_data  (data_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    // Transmit FSM state
    tx_state_e   state, state_next;
    logic [15:0] baud_cnt, baud_cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic        txd_next;

    // Control/status registers
    logic ie, ie_next;
    logic overflow, overflow_next;
    logic ready_next;
    logic busy;

    assign busy = (state != TX_IDLE) | ~fifo_empty;

    // Next-state logic: frame sequencing, FIFO pops and the txd level for the current state
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        fifo_pop      = 1'b0;
        txd_next      = 1'b1;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_head;
                    baud_cnt_next = BAUD_RELOAD;
                    state_next    = TX_START;
                end
            end
            TX_START: begin
                txd_next = 1'b0;
                if (baud_cnt == '0) begin
                    baud_cnt_next = BAUD_RELOAD;
                    bit_idx_next  = '0;
                    state_next    = TX_DATA;
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                txd_next = shift[0];
                if (baud_cnt == '0) begin
                    baud_cnt_next = BAUD_RELOAD;
                    shift_next    = {1'b0, shift[7:1]};
                    if (bit_idx == LAST_DATA_BIT) begin
                        state_next = TX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            TX_STOP: begin
                txd_next = 1'b1;
                if (baud_cnt == '0) begin
                    // Chain straight into the next frame when more data is queued
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        shift_next    = fifo_head;
                        baud_cnt_next = BAUD_RELOAD;
                        state_next    = TX_START;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt - 16'd1;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // FSM, shifter and registered txd; txd lags the state by one cycle for a glitch-free line
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            txd      <= txd_next;
        end
    end

    // Bus register updates; a dropped write setting overflow wins over a clearing status read
    always_comb begin
        ie_next       = write_control ? data_in[0] : ie;
        overflow_next = overflow;
        if (read_status)             overflow_next = 1'b0;
        if (write_data && fifo_full) overflow_next = 1'b1;
        ready_next    = ie_next & (fifo_count_next == '0) & (state_next == TX_IDLE);
    end

    // Control register, sticky overflow and interrupt request
    always_ff @(posedge clk) begin
        if (reset) begin
            ie       <= 1'b0;
            overflow <= 1'b0;
            ready    <= 1'b0;
        end else begin
            ie       <= ie_next;
            overflow <= overflow_next;
            ready    <= ready_next;
        end
    end

    // Read mux, combinational so data is valid in the same cycle as en
    always_comb begin
        data_out = '0;
        if (addr == SERIAL_ADDR_DATA) begin
            data_out[STATUS_FULL_BIT]     = fifo_full;
            data_out[STATUS_BUSY_BIT]     = busy;
            data_out[STATUS_OVERFLOW_BIT] = overflow;
        end else begin
            data_out = 8'(fifo_count);
        end
    end

endmodule

// File: tb/tb_serial_port_transmitter.sv
// Directed bench for serial_port_transmitter with CLOCK_DIVIDER=4 and a
// 4-entry FIFO. A line monitor decodes frames off txd and compares each
// byte against a scoreboard queue filled when bytes are written.
module tb_serial_port_transmitter;

    localparam int DIV = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       wr = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       txd;
    logic       ready;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         start_log[$];
    int         starts_seen = 0;
    int         frames_done = 0;

    serial_port_transmitter #(
        .CLOCK_DIVIDER   (DIV),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .txd      (txd),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        en = 1'b1;
        wr = 1'b1;
        addr = a;
        data_in = d;
        tick();
        en = 1'b0;
        wr = 1'b0;
    endtask

    // Read checks the combinational value, then lets the access reach an edge
    task automatic read_check(input logic a, input logic [7:0] expected, input string tag);
        en = 1'b1;
        wr = 1'b0;
        addr = a;
        #1;
        check(tag, 32'(data_out), 32'(expected));
        tick();
        en = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_starts(input int target, input string tag);
        int n = 0;
        while (starts_seen < target && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(starts_seen >= target), 32'd1);
    endtask

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (frames_done < target && n < 1000) begin
            tick();
            n++;
        end
        check(tag, 32'(frames_done >= target), 32'd1);
        repeat (3) tick();
    endtask

    // Line monitor: bit b of a frame is sampled in the middle of its DIV-cycle window
    int         mon_off = 0;
    bit         in_frame = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (txd === 1'b0) begin
                    in_frame = 1'b1;
                    mon_off = 0;
                    start_log.push_back(cyc);
                    starts_seen++;
                end
            end else begin
                mon_off++;
            end
            if (in_frame) begin
                if (mon_off == DIV / 2) check("start_bit", 32'(txd), 32'd0);
                if (mon_off >= DIV + DIV / 2 && mon_off < 9 * DIV && (mon_off % DIV) == DIV / 2)
                    mon_byte[mon_off / DIV - 1] = txd;
                if (mon_off == 9 * DIV + DIV / 2) check("stop_bit", 32'(txd), 32'd1);
                if (mon_off == FRAME - 1) begin
                    in_frame = 1'b0;
                    frames_done++;
                    check("frame_pending", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int w;
        int s;
        int base;
        int saved;

        // Reset and reset values
        repeat (3) tick();
        reset = 1'b0;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_ready", 32'(ready), 32'd0);
        read_check(1'b0, 8'h00, "reset_status");
        read_check(1'b1, 8'h00, "reset_count");

        // Single frame: latency, length and busy release
        base = starts_seen;
        bus_write(1'b0, 8'h55);
        w = cyc;
        exp_q.push_back(8'h55);
        wait_starts(base + 1, "t1_start_seen");
        check("t1_start_latency", 32'(start_log[base]), 32'(w + 2));
        wait_until(w + 40);
        read_check(1'b0, 8'h02, "t1_busy_in_stop");
        read_check(1'b0, 8'h00, "t1_idle_after_stop");
        wait_frames(1, "t1_frame_done");

        // Back-to-back frames
        base = starts_seen;
        bus_write(1'b0, 8'h01);
        bus_write(1'b0, 8'h80);
        bus_write(1'b0, 8'hFF);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hFF);
        read_check(1'b1, 8'h02, "t2_count_after_pop");
        wait_frames(4, "t2_frames_done");
        check("t2_gap_0_1", 32'(start_log[base + 1] - start_log[base]), 32'(FRAME));
        check("t2_gap_1_2", 32'(start_log[base + 2] - start_log[base + 1]), 32'(FRAME));

        // Fill past capacity: one byte in flight, four buffered, sixth dropped
        for (int i = 0; i < 6; i++) begin
            bus_write(1'b0, 8'hA0 + 8'(i));
            if (i < 5) exp_q.push_back(8'hA0 + 8'(i));
        end
        read_check(1'b0, 8'h07, "t3_status_overflow");
        read_check(1'b0, 8'h03, "t3_status_cleared");
        wait_frames(9, "t3_frames_done");

        // Write to a full FIFO on the same edge as a STOP->START pop
        base = starts_seen;
        for (int i = 0; i < 5; i++) begin
            bus_write(1'b0, 8'hB0 + 8'(i));
            exp_q.push_back(8'hB0 + 8'(i));
        end
        w = cyc - 4;
        wait_starts(base + 1, "t6_start_seen");
        s = start_log[base];
        check("t6_start_latency", 32'(s), 32'(w + 2));
        wait_until(s + 37);
        read_check(1'b1, 8'h04, "t6_count_full");
        bus_write(1'b0, 8'hB5);
        read_check(1'b1, 8'h03, "t6_count_after_pop");
        read_check(1'b0, 8'h06, "t6_status_overflow");
        read_check(1'b0, 8'h02, "t6_status_cleared");
        wait_frames(14, "t6_frames_done");

        // Interrupt enable and release
        check("t4_ready_before_ie", 32'(ready), 32'd0);
        bus_write(1'b1, 8'h01);
        check("t4_ready_after_ie", 32'(ready), 32'd1);
        bus_write(1'b0, 8'h3C);
        w = cyc;
        exp_q.push_back(8'h3C);
        check("t4_ready_after_push", 32'(ready), 32'd0);
        wait_until(w + 40);
        check("t4_ready_in_stop", 32'(ready), 32'd0);
        tick();
        check("t4_ready_after_frame", 32'(ready), 32'd1);
        wait_frames(15, "t4_frames_done");

        // Reset during data bit 3, with a competing bus write on the reset edge
        base = starts_seen;
        bus_write(1'b0, 8'h96);
        bus_write(1'b0, 8'h69);
        w = cyc - 1;
        wait_starts(base + 1, "t5_start_seen");
        s = start_log[base];
        wait_until(s + 17);
        reset = 1'b1;
        en = 1'b1;
        wr = 1'b1;
        addr = 1'b0;
        data_in = 8'hEE;
        tick();
        reset = 1'b0;
        en = 1'b0;
        wr = 1'b0;
        exp_q.delete();
        check("t5_txd_after_reset", 32'(txd), 32'd1);
        check("t5_ready_after_reset", 32'(ready), 32'd0);
        read_check(1'b1, 8'h00, "t5_count_after_reset");
        read_check(1'b0, 8'h00, "t5_status_after_reset");
        saved = starts_seen;
        repeat (100) tick();
        check("t5_no_new_frame", 32'(starts_seen), 32'(saved));
        check("t5_txd_idle", 32'(txd), 32'd1);
        check("t5_ready_ie_cleared", 32'(ready), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
